// File: rtl/cam_link_rx_unpack_if.sv
// Camera Link style video bus: sampled frame/line/pixel inputs
// plus the packed 64-bit word stream and status outputs.
//
// Signals:
//   IN_FRAME        frame valid
//   IN_LINE         line valid (pixel present with IN_FRAME)
//   IN_VIDEO_DATA   16-bit pixel
//   OUT_DATA        packed word, first pixel in [63:48]
//   OUT_DATA_VALID  one-cycle strobe per word
//   OUT_SOF         first word of a frame
//   OUT_EOL         last word of a line
//   OUT_LINE_ERR    line length mismatch pulse
//   OUT_FRAME_ERR   line count mismatch pulse
//   OUT_LINE_COUNT  lines completed in the current frame
//
// master drives the video stream, slave is the unpacker.
interface cam_link_rx_unpack_if;
    logic        IN_FRAME;
    logic        IN_LINE;
    logic [15:0] IN_VIDEO_DATA;
    logic [63:0] OUT_DATA;
    logic        OUT_DATA_VALID;
    logic        OUT_SOF;
    logic        OUT_EOL;
    logic        OUT_LINE_ERR;
    logic        OUT_FRAME_ERR;
    logic [15:0] OUT_LINE_COUNT;

    modport master (
        output IN_FRAME,
        output IN_LINE,
        output IN_VIDEO_DATA,
        input  OUT_DATA,
        input  OUT_DATA_VALID,
        input  OUT_SOF,
        input  OUT_EOL,
        input  OUT_LINE_ERR,
        input  OUT_FRAME_ERR,
        input  OUT_LINE_COUNT
    );

    modport slave (
        input  IN_FRAME,
        input  IN_LINE,
        input  IN_VIDEO_DATA,
        output OUT_DATA,
        output OUT_DATA_VALID,
        output OUT_SOF,
        output OUT_EOL,
        output OUT_LINE_ERR,
        output OUT_FRAME_ERR,
        output OUT_LINE_COUNT
    );
endinterface

// File: rtl/cam_link_rx_unpack.sv
// Camera Link receive unpacker: packs four 16-bit pixels into
// one 64-bit A_B_C_D word with SOF/EOL and window checking.
//
// Ports:
//   CLK_OUT  pixel clock, rising edge
//   nRESET   synchronous active-low reset
//   bus      cam_link_rx_unpack_if.slave (video in, words out)
//
// Parameters:
//   video_win_size_x  expected pixels per line (>=1)
//   video_win_size_y  expected lines per frame (>=1)
module cam_link_rx_unpack #(
    parameter int video_win_size_x = 640,
    parameter int video_win_size_y = 512
) (
    input  logic                 CLK_OUT,
    input  logic                 nRESET,
    cam_link_rx_unpack_if.slave  bus
);

    localparam logic [16:0] WIN_X = 17'(video_win_size_x);
    localparam logic [15:0] WIN_Y = 16'(video_win_size_y);

    typedef enum logic [2:0] {
        SYNC,
        IDLE,
        FRAME,
        LINE,
        EOL,
        FEND
    } state_t;

    state_t      state;

    // input sample stage
    logic        r_vld;
    logic        r_frame;
    logic        r_line;
    logic [15:0] r_data;

    // packing
    logic [63:0] pack;
    logic [1:0]  slot;
    logic        full;
    logic        sof_arm;
    logic        frm_end;

    // counters
    logic [16:0] pix_cnt;
    logic [15:0] line_cnt;

    // registered outputs
    logic [63:0] o_data;
    logic        o_valid;
    logic        o_sof;
    logic        o_eol;
    logic        o_lerr;
    logic        o_ferr;

    assign bus.OUT_DATA       = o_data;
    assign bus.OUT_DATA_VALID = o_valid;
    assign bus.OUT_SOF        = o_sof;
    assign bus.OUT_EOL        = o_eol;
    assign bus.OUT_LINE_ERR   = o_lerr;
    assign bus.OUT_FRAME_ERR  = o_ferr;
    assign bus.OUT_LINE_COUNT = line_cnt;

    // Writing slot 0 clears B..D, so a partial word
    // always carries zeros in its unfilled slots.
    function automatic logic [63:0] put(
        input logic [63:0] p,
        input logic [1:0]  s,
        input logic [15:0] d
    );
        logic [63:0] r;
        case (s)
            2'd0:    r = {d, 48'h0};
            2'd1:    r = {p[63:48], d, p[31:0]};
            2'd2:    r = {p[63:32], d, p[15:0]};
            default: r = {p[63:16], d};
        endcase
        return r;
    endfunction

    function automatic logic [16:0] inc17(
        input logic [16:0] v
    );
        return (v == 17'h1FFFF) ? v : v + 17'd1;
    endfunction

    function automatic logic [15:0] inc16(
        input logic [15:0] v
    );
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge CLK_OUT) begin
        if (!nRESET) begin
            state    <= SYNC;
            r_vld    <= 1'b0;
            r_frame  <= 1'b0;
            r_line   <= 1'b0;
            r_data   <= 16'h0;
            pack     <= 64'h0;
            slot     <= 2'd0;
            full     <= 1'b0;
            sof_arm  <= 1'b0;
            frm_end  <= 1'b0;
            pix_cnt  <= 17'h0;
            line_cnt <= 16'h0;
            o_data   <= 64'h0;
            o_valid  <= 1'b0;
            o_sof    <= 1'b0;
            o_eol    <= 1'b0;
            o_lerr   <= 1'b0;
            o_ferr   <= 1'b0;
        end else begin
            // r_vld keeps SYNC from trusting the
            // cleared sample left by reset.
            r_vld   <= 1'b1;
            r_frame <= bus.IN_FRAME;
            r_line  <= bus.IN_LINE;
            r_data  <= bus.IN_VIDEO_DATA;

            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_eol   <= 1'b0;
            o_lerr  <= 1'b0;
            o_ferr  <= 1'b0;

            case (state)
                SYNC: begin
                    if (r_vld && !r_frame)
                        state <= IDLE;
                end

                IDLE: begin
                    if (r_frame) begin
                        line_cnt <= 16'h0;
                        sof_arm  <= 1'b1;
                        if (r_line) begin
                            pack    <= {r_data, 48'h0};
                            slot    <= 2'd1;
                            full    <= 1'b0;
                            pix_cnt <= 17'd1;
                            state   <= LINE;
                        end else begin
                            state <= FRAME;
                        end
                    end
                end

                FRAME: begin
                    if (!r_frame) begin
                        o_ferr <= (line_cnt != WIN_Y);
                        state  <= IDLE;
                    end else if (r_line) begin
                        pack    <= {r_data, 48'h0};
                        slot    <= 2'd1;
                        full    <= 1'b0;
                        pix_cnt <= 17'd1;
                        state   <= LINE;
                    end
                end

                LINE: begin
                    if (r_frame && r_line) begin
                        // A full word is held until the next
                        // pixel proves it is not the line's last.
                        if (full) begin
                            o_data  <= pack;
                            o_valid <= 1'b1;
                            o_sof   <= sof_arm;
                            sof_arm <= 1'b0;
                        end
                        pack    <= put(pack, slot, r_data);
                        slot    <= slot + 2'd1;
                        full    <= (slot == 2'd3);
                        pix_cnt <= inc17(pix_cnt);
                    end else begin
                        frm_end <= !r_frame;
                        state   <= EOL;
                    end
                end

                EOL: begin
                    o_data   <= pack;
                    o_valid  <= 1'b1;
                    o_eol    <= 1'b1;
                    o_sof    <= sof_arm;
                    sof_arm  <= 1'b0;
                    o_lerr   <= (pix_cnt != WIN_X);
                    line_cnt <= inc16(line_cnt);
                    full     <= 1'b0;
                    state    <= frm_end ? FEND : FRAME;
                end

                FEND: begin
                    o_ferr <= (line_cnt != WIN_Y);
                    state  <= IDLE;
                end

                default: begin
                    state <= SYNC;
                end
            endcase
        end
    end

endmodule
